mips_multicycle_ctrl: RTL
=========================

# mips_multicycle_ctrl

Multi-cycle control sequencer for the MIPS core. It consumes the opcode and funct fields produced by the instruction decode split and walks one instruction at a time through fetch, decode, execute, memory and writeback. Each cycle it drives the datapath strobes and mux selects, and it stalls on a ready handshake to a shared instruction/data memory.

## Interface
Parameters: none.

Ports:
- clk  in  1  system clock; all state changes on rising edge
- rst  in  1  asynchronous, active-high reset
- opcode  in  6  instruction[31:26]; valid from DECODE onward (IR already loaded)
- funct  in  6  instruction[5:0]
- alu_zero  in  1  ALU zero flag, used in BRANCH
- mem_ready  in  1  memory completes the current access this cycle
- pc_write, pc_write_cond, ir_write, reg_write  out  1 each  write strobes
- mem_read, mem_write, iord  out  1 each  memory request; iord=1 selects ALUOut as address
- alu_src_a  out  1  0 = PC, 1 = A
- alu_src_b  out  2  00 B, 01 const 4, 10 sign-ext imm, 11 sign-ext imm<<2
- alu_ctrl  out  4  ADD 0010, SUB 0110, AND 0000, OR 0001, SLT 0111, SLL 1000, SRL 1001
- pc_source  out  2  00 ALU result, 01 ALUOut, 10 jump target, 11 A (jr)
- reg_dst  out  2  00 rt, 01 rd, 10 r31
- mem_to_reg  out  2  00 ALUOut, 01 MDR, 10 PC
- branch_ne  out  1  invert zero sense for bne
- retired  out  1  one-cycle pulse per completed instruction
- halted  out  1  only with MIPS_CTRL_ILLEGAL_HALT_EN

## Operation
- States: INIT, FETCH, DECODE, MEM_ADDR, MEM_RD, MEM_WB, MEM_WR, EXEC_R, R_WB, EXEC_I, I_WB, BRANCH, JUMP, JAL, JR, HALT. Encoded in 4 bits.
- INIT: all outputs 0. Unconditionally goes to FETCH next cycle.
- FETCH: mem_read=1, iord=0, alu PC+4 (src_a 0, src_b 01, ADD), pc_source 00. ir_write and pc_write are asserted only while mem_ready=1. The FSM holds in FETCH while mem_ready=0.
- DECODE: alu PC+(imm<<2) (src_b 11, ADD) into ALUOut. Dispatch on opcode:
  - 0x23, 0x2B → MEM_ADDR
  - 0x00 → JR if funct=0x08, else EXEC_R
  - 0x08, 0x0A, 0x0C, 0x0D → EXEC_I
  - 0x04, 0x05 → BRANCH
  - 0x02 → JUMP
  - 0x03 → JAL
  - anything else → illegal (see Configuration)
- MEM_ADDR: A+imm. Next state is MEM_RD for lw, MEM_WR for sw.
- MEM_RD and MEM_WR: iord=1 with mem_read or mem_write held until mem_ready. MEM_RD → MEM_WB. MEM_WR → FETCH.
- MEM_WB: reg_write, reg_dst 00, mem_to_reg 01.
- EXEC_R: src_a 1, src_b 00, alu_ctrl from funct. Mapping: 0x20 ADD, 0x22 SUB, 0x24 AND, 0x25 OR, 0x2A SLT, 0x00 SLL, 0x02 SRL. Any other funct is illegal.
- R_WB: reg_write, reg_dst 01, mem_to_reg 00.
- EXEC_I: src_b 10. alu_ctrl: addi ADD, slti SLT, andi AND, ori OR.
- I_WB: reg_write, reg_dst 00.
- BRANCH: SUB A-B, pc_write_cond=1, pc_source 01, branch_ne=1 for opcode 0x05.
- JUMP: pc_write, pc_source 10.
- JAL: pc_write, pc_source 10, reg_write, reg_dst 10, mem_to_reg 10.
- JR: pc_write, pc_source 11.
- retired pulses on the last cycle of each instruction, i.e. any transition into FETCH other than from INIT.
- Unlisted outputs are 0 in every state.

## Timing
- Reset: state INIT. Every output is 0 while rst is high and during the first cycle after release.
- With zero memory wait, cycles per instruction: lw 5, sw 4, R-type 4, I-type 4, beq/bne 3, j/jal/jr 3.
- Each cycle mem_ready is low in FETCH, MEM_RD or MEM_WR adds one cycle. There is no timeout.
- mem_ready is ignored outside FETCH, MEM_RD and MEM_WR.
- rst asserted mid-instruction aborts immediately to INIT. No partial writeback follows.
- Strobes are combinational from state and mem_ready. The FSM register is the only sequential state.

## Configuration
- MIPS_CTRL_ILLEGAL_HALT_EN defined:
  - An illegal opcode or funct goes to HALT.
  - halted=1 and all strobes are 0; the FSM stays there until reset.
  - retired does not pulse.
- Not defined:
  - An illegal instruction returns from DECODE (or EXEC_R) to FETCH as a NOP, with retired pulsed.
  - The halted port is absent.

## Structure
- Shared package mips_pkg holds:
  - opcode and funct localparams
  - the state enum
  - alu_ctrl codes
  - the pc_source, reg_dst and mem_to_reg encodings
- Sub-module mips_alu_ctrl: combinational mapping of (state class, opcode, funct) to alu_ctrl plus an illegal flag.

## Test plan
- Reset release, mem_ready=1, lw (opcode 0x23) → INIT, FETCH, DECODE, MEM_ADDR, MEM_RD, MEM_WB. reg_write with mem_to_reg 01 in cycle 6; retired once.
- FETCH with mem_ready low for 3 cycles → mem_read held 4 cycles; ir_write/pc_write only in the 4th.
- R-type funct 0x22 → alu_ctrl 0110 in EXEC_R, then reg_write with reg_dst 01.
- bne (0x05) → BRANCH asserts pc_write_cond=1, branch_ne=1, pc_source 01; next state FETCH.
- jal (0x03) → JAL: pc_write=1, reg_write=1, reg_dst 10, mem_to_reg 10.
- Opcode 0x3F with macro → HALT, halted=1 until rst. Without macro → back to FETCH with retired=1.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared definitions for the multi-cycle MIPS control sequencer.
// Holds opcode/funct field values, the FSM state enum, ALU control codes,
// the ALU-control request classes and the datapath mux encodings.
package mips_pkg;

    localparam int unsigned OP_W  = 6;
    localparam int unsigned ALU_W = 4;
    localparam int unsigned SEL_W = 2;

    // opcode field values (instruction[31:26])
    localparam logic [OP_W-1:0] OP_RTYPE = 6'h00;
    localparam logic [OP_W-1:0] OP_J     = 6'h02;
    localparam logic [OP_W-1:0] OP_JAL   = 6'h03;
    localparam logic [OP_W-1:0] OP_BEQ   = 6'h04;
    localparam logic [OP_W-1:0] OP_BNE   = 6'h05;
    localparam logic [OP_W-1:0] OP_ADDI  = 6'h08;
    localparam logic [OP_W-1:0] OP_SLTI  = 6'h0A;
    localparam logic [OP_W-1:0] OP_ANDI  = 6'h0C;
    localparam logic [OP_W-1:0] OP_ORI   = 6'h0D;
    localparam logic [OP_W-1:0] OP_LW    = 6'h23;
    localparam logic [OP_W-1:0] OP_SW    = 6'h2B;

    // funct field values (instruction[5:0])
    localparam logic [OP_W-1:0] FN_SLL = 6'h00;
    localparam logic [OP_W-1:0] FN_SRL = 6'h02;
    localparam logic [OP_W-1:0] FN_JR  = 6'h08;
    localparam logic [OP_W-1:0] FN_ADD = 6'h20;
    localparam logic [OP_W-1:0] FN_SUB = 6'h22;
    localparam logic [OP_W-1:0] FN_AND = 6'h24;
    localparam logic [OP_W-1:0] FN_OR  = 6'h25;
    localparam logic [OP_W-1:0] FN_SLT = 6'h2A;

    typedef enum logic [3:0] {
        S_INIT, S_FETCH, S_DECODE, S_MEM_ADDR,
        S_MEM_RD, S_MEM_WB, S_MEM_WR, S_EXEC_R,
        S_R_WB, S_EXEC_I, S_I_WB, S_BRANCH,
        S_JUMP, S_JAL, S_JR, S_HALT
    } state_t;

    // ALU control codes
    localparam logic [ALU_W-1:0] ALU_AND = 4'b0000;
    localparam logic [ALU_W-1:0] ALU_OR  = 4'b0001;
    localparam logic [ALU_W-1:0] ALU_ADD = 4'b0010;
    localparam logic [ALU_W-1:0] ALU_SUB = 4'b0110;
    localparam logic [ALU_W-1:0] ALU_SLT = 4'b0111;
    localparam logic [ALU_W-1:0] ALU_SLL = 4'b1000;
    localparam logic [ALU_W-1:0] ALU_SRL = 4'b1001;

    // What the current state asks of the ALU-control decoder
    typedef enum logic [2:0] {
        ACLS_NONE, ACLS_ADD, ACLS_SUB, ACLS_FUNCT, ACLS_IMM
    } alu_class_t;

    // pc_source encodings
    localparam logic [SEL_W-1:0] PCS_ALU    = 2'b00;
    localparam logic [SEL_W-1:0] PCS_ALUOUT = 2'b01;
    localparam logic [SEL_W-1:0] PCS_JUMP   = 2'b10;
    localparam logic [SEL_W-1:0] PCS_REG    = 2'b11;

    // reg_dst encodings
    localparam logic [SEL_W-1:0] RD_RT = 2'b00;
    localparam logic [SEL_W-1:0] RD_RD = 2'b01;
    localparam logic [SEL_W-1:0] RD_RA = 2'b10;

    // mem_to_reg encodings
    localparam logic [SEL_W-1:0] M2R_ALUOUT = 2'b00;
    localparam logic [SEL_W-1:0] M2R_MDR    = 2'b01;
    localparam logic [SEL_W-1:0] M2R_PC     = 2'b10;

endpackage

// File: rtl/mips_alu_ctrl.sv
// Combinational ALU-control decoder.
// Ports: cls (request class from the FSM), opcode, funct -> alu_ctrl code,
// illegal (funct/opcode not supported for the requested class).
module mips_alu_ctrl
    import mips_pkg::*;
(
    input  alu_class_t        cls,
    input  logic [OP_W-1:0]   opcode,
    input  logic [OP_W-1:0]   funct,
    output logic [ALU_W-1:0]  alu_ctrl,
    output logic              illegal
);

    always_comb begin
        alu_ctrl = '0;
        illegal  = 1'b0;
        case (cls)
            ACLS_NONE: ;
            ACLS_ADD:  alu_ctrl = ALU_ADD;
            ACLS_SUB:  alu_ctrl = ALU_SUB;
            ACLS_FUNCT: begin
                case (funct)
                    FN_ADD:  alu_ctrl = ALU_ADD;
                    FN_SUB:  alu_ctrl = ALU_SUB;
                    FN_AND:  alu_ctrl = ALU_AND;
                    FN_OR:   alu_ctrl = ALU_OR;
                    FN_SLT:  alu_ctrl = ALU_SLT;
                    FN_SLL:  alu_ctrl = ALU_SLL;
                    FN_SRL:  alu_ctrl = ALU_SRL;
                    default: illegal  = 1'b1;
                endcase
            end
            ACLS_IMM: begin
                case (opcode)
                    OP_ADDI: alu_ctrl = ALU_ADD;
                    OP_SLTI: alu_ctrl = ALU_SLT;
                    OP_ANDI: alu_ctrl = ALU_AND;
                    OP_ORI:  alu_ctrl = ALU_OR;
                    default: illegal  = 1'b1;
                endcase
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/mips_multicycle_ctrl.sv
// Multi-cycle MIPS control sequencer: walks each instruction through
// fetch/decode/execute/memory/writeback and drives datapath strobes and
// mux selects, stalling on mem_ready in FETCH, MEM_RD and MEM_WR.
// Ports: clk, rst (async active-high), opcode, funct, alu_zero, mem_ready in;
// write strobes, memory request, ALU/mux selects, branch_ne, retired out;
// halted out only when MIPS_CTRL_ILLEGAL_HALT_EN is defined.
// Option MIPS_CTRL_ILLEGAL_HALT_EN: illegal instructions park the FSM in
// HALT until reset; otherwise they retire as a NOP.
// Strobes are combinational from state (and mem_ready); the state register
// is the only storage.
module mips_multicycle_ctrl
    import mips_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic [OP_W-1:0]   opcode,
    input  logic [OP_W-1:0]   funct,
    input  logic              alu_zero,
    input  logic              mem_ready,
    output logic              pc_write,
    output logic              pc_write_cond,
    output logic              ir_write,
    output logic              reg_write,
    output logic              mem_read,
    output logic              mem_write,
    output logic              iord,
    output logic              alu_src_a,
    output logic [SEL_W-1:0]  alu_src_b,
    output logic [ALU_W-1:0]  alu_ctrl,
    output logic [SEL_W-1:0]  pc_source,
    output logic [SEL_W-1:0]  reg_dst,
    output logic [SEL_W-1:0]  mem_to_reg,
    output logic              branch_ne,
`ifdef MIPS_CTRL_ILLEGAL_HALT_EN
    output logic              halted,
`endif
    output logic              retired
);

`ifdef MIPS_CTRL_ILLEGAL_HALT_EN
    localparam state_t ILLEGAL_NEXT = S_HALT;
`else
    localparam state_t ILLEGAL_NEXT = S_FETCH;
`endif

    state_t     state, next_state;
    alu_class_t alu_cls;
    logic       funct_illegal;

    // alu_zero gates pc_write_cond inside the datapath; control does not need it
    logic unused_alu_zero;
    assign unused_alu_zero = alu_zero;

    mips_alu_ctrl u_alu_ctrl (
        .cls      (alu_cls),
        .opcode   (opcode),
        .funct    (funct),
        .alu_ctrl (alu_ctrl),
        .illegal  (funct_illegal)
    );

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_INIT;
        else     state <= next_state;
    end

    // Next-state logic
    always_comb begin
        next_state = state;
        case (state)
            S_INIT:     next_state = S_FETCH;
            S_FETCH:    if (mem_ready) next_state = S_DECODE;
            S_DECODE: begin
                case (opcode)
                    OP_LW, OP_SW:                     next_state = S_MEM_ADDR;
                    OP_RTYPE:                         next_state = (funct == FN_JR) ? S_JR : S_EXEC_R;
                    OP_ADDI, OP_SLTI, OP_ANDI, OP_ORI: next_state = S_EXEC_I;
                    OP_BEQ, OP_BNE:                   next_state = S_BRANCH;
                    OP_J:                             next_state = S_JUMP;
                    OP_JAL:                           next_state = S_JAL;
                    default:                          next_state = ILLEGAL_NEXT;
                endcase
            end
            S_MEM_ADDR: next_state = (opcode == OP_SW) ? S_MEM_WR : S_MEM_RD;
            S_MEM_RD:   if (mem_ready) next_state = S_MEM_WB;
            S_MEM_WR:   if (mem_ready) next_state = S_FETCH;
            S_EXEC_R:   next_state = funct_illegal ? ILLEGAL_NEXT : S_R_WB;
            S_EXEC_I:   next_state = S_I_WB;
            S_MEM_WB, S_R_WB, S_I_WB, S_BRANCH, S_JUMP, S_JAL, S_JR:
                        next_state = S_FETCH;
            S_HALT:     next_state = S_HALT;
            default:    next_state = S_INIT;
        endcase
    end

    // Output decode
    always_comb begin
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        ir_write      = 1'b0;
        reg_write     = 1'b0;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        iord          = 1'b0;
        alu_src_a     = 1'b0;
        alu_src_b     = 2'b00;
        alu_cls       = ACLS_NONE;
        pc_source     = PCS_ALU;
        reg_dst       = RD_RT;
        mem_to_reg    = M2R_ALUOUT;
        branch_ne     = 1'b0;
        case (state)
            S_FETCH: begin
                mem_read  = 1'b1;
                alu_src_b = 2'b01;
                alu_cls   = ACLS_ADD;
                ir_write  = mem_ready;
                pc_write  = mem_ready;
            end
            S_DECODE: begin
                alu_src_b = 2'b11;
                alu_cls   = ACLS_ADD;
            end
            S_MEM_ADDR: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
                alu_cls   = ACLS_ADD;
            end
            S_MEM_RD: begin
                mem_read = 1'b1;
                iord     = 1'b1;
            end
            S_MEM_WR: begin
                mem_write = 1'b1;
                iord      = 1'b1;
            end
            S_MEM_WB: begin
                reg_write  = 1'b1;
                reg_dst    = RD_RT;
                mem_to_reg = M2R_MDR;
            end
            S_EXEC_R: begin
                alu_src_a = 1'b1;
                alu_cls   = ACLS_FUNCT;
            end
            S_R_WB: begin
                reg_write = 1'b1;
                reg_dst   = RD_RD;
            end
            S_EXEC_I: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
                alu_cls   = ACLS_IMM;
            end
            S_I_WB:     reg_write = 1'b1;
            S_BRANCH: begin
                alu_src_a     = 1'b1;
                alu_cls       = ACLS_SUB;
                pc_write_cond = 1'b1;
                pc_source     = PCS_ALUOUT;
                branch_ne     = (opcode == OP_BNE);
            end
            S_JUMP: begin
                pc_write  = 1'b1;
                pc_source = PCS_JUMP;
            end
            S_JAL: begin
                pc_write   = 1'b1;
                pc_source  = PCS_JUMP;
                reg_write  = 1'b1;
                reg_dst    = RD_RA;
                mem_to_reg = M2R_PC;
            end
            S_JR: begin
                pc_write  = 1'b1;
                pc_source = PCS_REG;
            end
            default: ;
        endcase
    end

    // Last cycle of an instruction: any entry into FETCH except the one out of reset
    assign retired = (next_state == S_FETCH) && (state != S_INIT) && (state != S_FETCH);

`ifdef MIPS_CTRL_ILLEGAL_HALT_EN
    assign halted = (state == S_HALT);
`endif

endmodule
